// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, segment bit positions, polarity helper.
// Latency: n/a (package, constants and a pure function only).
// Backpressure: n/a.
package seven_seg_pkg;

    // Bit positions inside the 8-bit segment word {dp,g,f,e,d,c,b,a}.
    localparam int SEG_DP = 7;
    localparam int SEG_G  = 6;
    localparam int SEG_A  = 0;

    // Active-high segment words: nothing lit / everything lit.
    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [7:0] SEG_ON  = 8'hFF;

    // Active-high {g..a} patterns, indexed by hex nibble 0..F.
    localparam logic [0:15][6:0] GLYPH_TABLE = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Convert an active-high segment word to the board's pin polarity.
    function automatic logic [7:0] seg_polarity(input logic [7:0] active_high,
                                                input logic       active_low);
        return active_low ? ~active_high : active_high;
    endfunction

endpackage

// File: rtl/hex_to_seg_glyph.sv
// Combinational hex nibble + decimal point to active-high 8-bit segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
// Ports: nibble (hex digit), dp (decimal point request), glyph ({dp,g..a}, 1 = lit).
module hex_to_seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] glyph
);

    always_comb begin
        glyph                = SEG_OFF;
        glyph[SEG_G:SEG_A]   = GLYPH_TABLE[nibble];
        glyph[SEG_DP]        = dp;
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: latches a hex word and scans one digit per refresh slot.
// Latency: seg_out/an_out are registered, 1 cycle behind the slot counter and digit index.
// Backpressure: none; load is accepted every cycle, the display scans free-running.
// Ports: clk, reset (sync, active-high), load/data_in/dp_in/blank_in (shadow capture),
//        lz_suppress (live), seg_out {dp,g..a}, an_out (one-hot digit enable), digit_idx.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int                   CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_BLNK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx_q;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_lz;
    logic                    lz_chain;
    logic                    dark;
    logic                    in_blank;
    logic [7:0]              glyph;
    logic [7:0]              seg_lit;
    logic [NUM_DIGITS-1:0]   an_onehot;

    assign digit_idx = idx_q;

    // Shadow registers: the display shows a stable snapshot between loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (load) begin
            data_q  <= data_in;
            dp_q    <= dp_in;
            blank_q <= blank_in;
        end
    end

    // Slot counter and digit index; the index advances on counter wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx_q <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Select the current digit's fields. lz_chain walks from the most significant
    // digit downwards and stays set only while every nibble seen so far is zero.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        lz_chain  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_chain = lz_chain & (data_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = data_q[4*i +: 4];
                cur_dp    = dp_q[i];
                cur_blank = blank_q[i];
                cur_lz    = lz_chain && (i > 0);  // digit 0 always shows, so "0" is visible
            end
        end
    end

    hex_to_seg_glyph u_glyph (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .glyph  (glyph)
    );

    // A dark digit keeps its anode enabled but lights nothing, dp included.
    assign dark      = cur_blank | (lz_suppress & cur_lz);
    assign seg_lit   = glyph & (dark ? SEG_OFF : SEG_ON);
    assign an_onehot = AN_ONE << idx_q;
    assign in_blank  = (cnt < CNT_BLNK);

    // Registered pins; the blanking window at the start of each slot keeps all
    // anodes off while segments settle, avoiding ghosting onto the next digit.
    always_ff @(posedge clk) begin
        if (reset || in_blank) begin
            seg_out <= seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
            an_out  <= AN_OFF;
        end else begin
            seg_out <= seg_polarity(seg_lit, SEG_ACTIVE_LOW);
            an_out  <= AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
        end
    end

endmodule
